// File: rtl/bf_program_loader.sv
// bf_program_loader: turns an ASCII BF character stream into 4-bit opcodes,
// writes them into program memory from address 0, then appends the stop opcode.
// Bracket balance and memory capacity are checked as the stream arrives.
module bf_program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  TERM_CHAR = 8'h21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [3:0]        prog_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STOP_WR,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0]        OP_OPEN   = 4'h4;
  localparam logic [3:0]        OP_CLOSE  = 4'h5;
  localparam logic [3:0]        OP_STOP   = 4'hF;
  // The top slot is kept free so the stop opcode always fits.
  localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] depth;

  logic       is_term;
  logic       is_legal;
  logic [3:0] opcode;
  logic       accept;

  // Translate the incoming character into an opcode; anything else is ignored.
  always_comb begin
    is_legal = 1'b1;
    opcode   = 4'h0;
    case (char_data)
      8'h3C:   opcode = 4'h0;
      8'h3E:   opcode = 4'h1;
      8'h2B:   opcode = 4'h2;
      8'h2D:   opcode = 4'h3;
      8'h5B:   opcode = 4'h4;
      8'h5D:   opcode = 4'h5;
      8'h2E:   opcode = 4'h6;
      8'h2C:   opcode = 4'h7;
      default: is_legal = 1'b0;
    endcase
  end

  // A pending restart blocks the handshake so the concurrent character is dropped.
  assign is_term    = (char_data == TERM_CHAR);
  assign char_ready = (state == S_LOAD) && !start;
  assign accept     = char_valid && char_ready;

  // Load sequencer: all outputs are registered, write strobe is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      depth      <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= 4'h0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      err_code   <= 2'd0;
      prog_len   <= '0;
    end else begin
      prog_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LOAD;
            wr_ptr     <= '0;
            depth      <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            err_code   <= 2'd0;
            prog_len   <= '0;
            busy       <= 1'b1;
          end
        end

        S_LOAD: begin
          if (start) begin
            wr_ptr <= '0;
            depth  <= '0;
          end else if (accept) begin
            if (is_term) begin
              if (depth != '0) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
                err_code   <= 2'd2;
                busy       <= 1'b0;
              end else begin
                state      <= S_STOP_WR;
                prog_we    <= 1'b1;
                prog_addr  <= wr_ptr;
                prog_wdata <= OP_STOP;
              end
            end else if (is_legal) begin
              if ((opcode == OP_CLOSE) && (depth == '0)) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
                err_code   <= 2'd1;
                busy       <= 1'b0;
              end else if (wr_ptr == LAST_SLOT) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
                err_code   <= 2'd3;
                busy       <= 1'b0;
              end else begin
                prog_we    <= 1'b1;
                prog_addr  <= wr_ptr;
                prog_wdata <= opcode;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                if (opcode == OP_OPEN) begin
                  depth <= depth + ADDR_W'(1);
                end else if (opcode == OP_CLOSE) begin
                  depth <= depth - ADDR_W'(1);
                end
              end
            end
          end
        end

        S_STOP_WR: begin
          state     <= S_DONE;
          prog_len  <= wr_ptr;
          load_done <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// tb_bf_program_loader: drives random and directed character streams into the
// loader and compares every write and status output against a reference model.
module tb_bf_program_loader;

  localparam logic [7:0] TERM = 8'h21;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [3:0] prog_wdata;
  logic       busy;
  logic       load_done;
  logic       load_error;
  logic [1:0] err_code;
  logic [7:0] prog_len;

  logic       s3_start;
  logic       s3_valid;
  logic [7:0] s3_data;
  logic       s3_ready;
  logic       s3_we;
  logic [2:0] s3_addr;
  logic [3:0] s3_wdata;
  logic       s3_busy;
  logic       s3_done;
  logic       s3_error;
  logic [1:0] s3_code;
  logic [2:0] s3_len;

  int check_count = 0;
  int error_count = 0;

  logic [7:0] stream_q[$];
  int         exp_we[$];
  int         exp_addr[$];
  int         exp_data[$];
  int         exp_count;
  int         exp_err;
  int         exp_len;

  always #5 clk = ~clk;

  bf_program_loader #(.ADDR_W(8), .TERM_CHAR(TERM)) dut (
    .clk(clk), .reset(reset), .start(start), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy),
    .load_done(load_done), .load_error(load_error), .err_code(err_code),
    .prog_len(prog_len)
  );

  bf_program_loader #(.ADDR_W(3), .TERM_CHAR(TERM)) dut3 (
    .clk(clk), .reset(reset), .start(s3_start), .char_valid(s3_valid),
    .char_data(s3_data), .char_ready(s3_ready), .prog_we(s3_we),
    .prog_addr(s3_addr), .prog_wdata(s3_wdata), .busy(s3_busy),
    .load_done(s3_done), .load_error(s3_error), .err_code(s3_code),
    .prog_len(s3_len)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int opcodeOf(input logic [7:0] c);
    case (c)
      8'h3C:   return 0;
      8'h3E:   return 1;
      8'h2B:   return 2;
      8'h2D:   return 3;
      8'h5B:   return 4;
      8'h5D:   return 5;
      8'h2E:   return 6;
      8'h2C:   return 7;
      default: return -1;
    endcase
  endfunction

  function automatic void pushExp(input int we, input int addr, input int data);
    exp_we.push_back(we);
    exp_addr.push_back(addr);
    exp_data.push_back(data);
  endfunction

  // Reference model: walks stream_q and lists, per accepted character, the write it causes.
  function automatic void modelLoad(input int cap);
    int writes;
    int opens;
    int op;
    writes = 0;
    opens  = 0;
    exp_we.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_count = 0;
    exp_err   = -1;
    exp_len   = 0;
    foreach (stream_q[i]) begin
      exp_count++;
      if (stream_q[i] == TERM) begin
        if (opens != 0) begin
          pushExp(0, 0, 0);
          exp_err = 2;
        end else begin
          pushExp(1, writes, 15);
          exp_err = 0;
          exp_len = writes;
        end
        return;
      end
      op = opcodeOf(stream_q[i]);
      if (op < 0) begin
        pushExp(0, 0, 0);
        continue;
      end
      if (op == 5 && opens == 0) begin
        pushExp(0, 0, 0);
        exp_err = 1;
        return;
      end
      if (writes >= cap - 1) begin
        pushExp(0, 0, 0);
        exp_err = 3;
        return;
      end
      pushExp(1, writes, op);
      writes++;
      if (op == 4) opens++;
      if (op == 5) opens--;
    end
  endfunction

  function automatic void loadText(input string txt);
    stream_q.delete();
    for (int i = 0; i < txt.len(); i++) stream_q.push_back(txt[i]);
  endfunction

  // Random program: either free-form or kept bracket-balanced, always terminated.
  function automatic void randomProgram();
    logic [7:0] alpha[11] = '{8'h3C, 8'h3E, 8'h2B, 8'h2D, 8'h5B, 8'h5D,
                              8'h2E, 8'h2C, 8'h20, 8'h61, 8'h0A};
    int         len;
    int         opens;
    bit         balanced;
    logic [7:0] c;
    stream_q.delete();
    len      = $urandom_range(1, 30);
    balanced = 1'($urandom_range(0, 1));
    opens    = 0;
    for (int i = 0; i < len; i++) begin
      c = alpha[$urandom_range(0, 10)];
      if (balanced && c == 8'h5D && opens == 0) c = 8'h2B;
      if (c == 8'h5B) opens++;
      if (c == 8'h5D && opens > 0) opens--;
      stream_q.push_back(c);
    end
    if (balanced) begin
      for (int i = 0; i < opens; i++) stream_q.push_back(8'h5D);
    end
    stream_q.push_back(TERM);
  endfunction

  task automatic pulseStart();
    @(negedge clk);
    start      = 1'b1;
    char_valid = 1'b0;
    #1;
    checkOutput("start_ready", 32'(char_ready), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs stream_q through the main loader; gap<0 picks random idle cycles between characters.
  task automatic applyStimulus(input int gap);
    int g;
    modelLoad(256);
    pulseStart();
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_done", 32'(load_done), 0);
    checkOutput("start_error", 32'(load_error), 0);
    checkOutput("start_code", 32'(err_code), 0);
    checkOutput("start_len", 32'(prog_len), 0);
    checkOutput("start_we", 32'(prog_we), 0);
    for (int i = 0; i < exp_count; i++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        char_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("gap_we", 32'(prog_we), 0);
      end
      char_valid = 1'b1;
      char_data  = stream_q[i];
      #1;
      checkOutput("ready", 32'(char_ready), 1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("we", 32'(prog_we), 32'(exp_we[i]));
      if (exp_we[i] != 0) begin
        checkOutput("addr", 32'(prog_addr), 32'(exp_addr[i]));
        checkOutput("wdata", 32'(prog_wdata), 32'(exp_data[i]));
      end
    end
    char_valid = 1'b0;
    if (exp_err == 0) begin
      checkOutput("stop_busy", 32'(busy), 1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_we", 32'(prog_we), 0);
      checkOutput("done", 32'(load_done), 1);
      checkOutput("done_error", 32'(load_error), 0);
      checkOutput("done_len", 32'(prog_len), 32'(exp_len));
      checkOutput("done_busy", 32'(busy), 0);
    end else begin
      checkOutput("err_flag", 32'(load_error), 1);
      checkOutput("err_code", 32'(err_code), 32'(exp_err));
      checkOutput("err_done", 32'(load_done), 0);
      checkOutput("err_busy", 32'(busy), 0);
      #1;
      checkOutput("err_ready", 32'(char_ready), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("err_hold_we", 32'(prog_we), 0);
      checkOutput("err_hold", 32'(load_error), 1);
    end
  endtask

  task automatic driveChar(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    s3_start   = 1'b0;
    s3_valid   = 1'b0;
    s3_data    = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we", 32'(prog_we), 0);
    checkOutput("rst_addr", 32'(prog_addr), 0);
    checkOutput("rst_wdata", 32'(prog_wdata), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(load_done), 0);
    checkOutput("rst_error", 32'(load_error), 0);
    checkOutput("rst_code", 32'(err_code), 0);
    checkOutput("rst_len", 32'(prog_len), 0);
    checkOutput("rst_ready", 32'(char_ready), 0);
    checkOutput("rst3_busy", 32'(s3_busy), 0);
    reset = 1'b0;

    loadText("+[->+<]!");
    applyStimulus(0);
    loadText("+ a\n.!");
    applyStimulus(1);
    loadText("]");
    applyStimulus(0);
    loadText("+!");
    applyStimulus(0);
    loadText("[[]!");
    applyStimulus(0);

    for (int n = 0; n < 25; n++) begin
      randomProgram();
      applyStimulus(-1);
    end

    // Restart in the middle of a load.
    pulseStart();
    driveChar(8'h2B);
    driveChar(8'h2B);
    char_valid = 1'b1;
    char_data  = 8'h2B;
    start      = 1'b1;
    #1;
    checkOutput("mid_start_ready", 32'(char_ready), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid_start_we", 32'(prog_we), 0);
    checkOutput("mid_start_busy", 32'(busy), 1);
    driveChar(8'h2B);
    checkOutput("mid_first_we", 32'(prog_we), 1);
    checkOutput("mid_first_addr", 32'(prog_addr), 0);
    checkOutput("mid_first_data", 32'(prog_wdata), 2);
    driveChar(TERM);
    checkOutput("mid_stop_addr", 32'(prog_addr), 1);
    checkOutput("mid_stop_data", 32'(prog_wdata), 15);
    char_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_done", 32'(load_done), 1);
    checkOutput("mid_len", 32'(prog_len), 1);

    // Reset in the middle of a load.
    pulseStart();
    driveChar(8'h2B);
    checkOutput("pre_reset_we", 32'(prog_we), 1);
    char_data = 8'h2D;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_we", 32'(prog_we), 0);
    checkOutput("mid_rst_addr", 32'(prog_addr), 0);
    checkOutput("mid_rst_wdata", 32'(prog_wdata), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_len", 32'(prog_len), 0);
    checkOutput("mid_rst_ready", 32'(char_ready), 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(char_ready), 0);
    checkOutput("post_rst_we", 32'(prog_we), 0);
    char_valid = 1'b0;

    // Capacity limit on the 3-bit instance: eight opcodes into seven usable slots.
    loadText("++++++++");
    modelLoad(8);
    @(negedge clk);
    s3_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s3_start = 1'b0;
    for (int i = 0; i < exp_count; i++) begin
      s3_valid = 1'b1;
      s3_data  = stream_q[i];
      @(posedge clk);
      @(negedge clk);
      checkOutput("cap_we", 32'(s3_we), 32'(exp_we[i]));
      if (exp_we[i] != 0) begin
        checkOutput("cap_addr", 32'(s3_addr), 32'(exp_addr[i]));
        checkOutput("cap_data", 32'(s3_wdata), 32'(exp_data[i]));
      end
    end
    s3_valid = 1'b0;
    checkOutput("cap_error", 32'(s3_error), 1);
    checkOutput("cap_code", 32'(s3_code), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    checkOutput("cap_hold_we", 32'(s3_we), 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
